// File: rtl/serial_sub4_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives start/a/b; slave is the subtractor core.
interface serial_sub4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero, ovf
  );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: diff = a - b over WIDTH clocks, one full-subtractor cell.
// Optional signed overflow flag enabled by SERIAL_SUB_SIGNED_OVF_EN.
//
// state  | meaning
// IDLE   | waiting for start; results held
// RUN    | one difference bit per clock, LSB first
// DONE   | one-cycle done pulse; start here begins the next operation
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub4_if.slave bus
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bw_q, bw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  logic             d_bit;
  logic             bw_n;
  logic [WIDTH-1:0] res_n;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    d_bit = sa_q[0] ^ sb_q[0] ^ bw_q;
    bw_n  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
    res_n = {d_bit, res_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          res_d   = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_n;
        bw_d  = bw_n;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the result with the final bit merged in.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = res_n;
          borrow_d = bw_n;
          zero_d   = (res_n == '0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign bus.ovf    = ovf_q;
`else
  assign bus.ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: directed cases plus randomized
// back-to-back traffic against an arithmetic reference model.
module tb_serial_sub4;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk;
  logic rst;

  serial_sub4_if #(.WIDTH(W)) bus ();

  serial_sub4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: timing from the accept edge, values from plain arithmetic.
  int edge_n  = 0;
  int op_edge = -1;
  int m_a = 0, m_b = 0;
  int exp_diff = 0, exp_borrow = 0, exp_zero = 0, exp_ovf = 0;
  int exp_busy = 0, exp_done = 0;
  int m_done_cnt = 0, dut_done_cnt = 0;

  function automatic int sgn(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      op_edge    = -1;
      exp_diff   = 0;
      exp_borrow = 0;
      exp_zero   = 0;
      exp_ovf    = 0;
    end else begin
      if (op_edge >= 0 && edge_n == op_edge + W) begin
        int sd;
        exp_diff   = (m_a - m_b) & MASK;
        exp_borrow = (m_a < m_b) ? 1 : 0;
        exp_zero   = (exp_diff == 0) ? 1 : 0;
        sd = sgn(m_a) - sgn(m_b);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        exp_ovf = (sd > (1 << (W - 1)) - 1 || sd < -(1 << (W - 1))) ? 1 : 0;
`else
        exp_ovf = (sd == sd) ? 0 : 1;
`endif
        m_done_cnt++;
      end
      if (bus.start && (op_edge < 0 || edge_n >= op_edge + W + 1)) begin
        op_edge = edge_n;
        m_a     = int'(bus.a);
        m_b     = int'(bus.b);
      end
    end
    exp_busy = (op_edge >= 0 && edge_n >= op_edge && edge_n < op_edge + W) ? 1 : 0;
    exp_done = (op_edge >= 0 && edge_n == op_edge + W) ? 1 : 0;
    #1;
    if (bus.done) dut_done_cnt++;
    chk("busy",   int'(bus.busy),   exp_busy);
    chk("done",   int'(bus.done),   exp_done);
    chk("diff",   int'(bus.diff),   exp_diff);
    chk("borrow", int'(bus.borrow), exp_borrow);
    chk("zero",   int'(bus.zero),   exp_zero);
    chk("ovf",    int'(bus.ovf),    exp_ovf);
  end

  // Single operation: pulse start for one edge, wait (bounded) for done.
  task automatic do_op(input int a, input int b, output int cyc, output int bcnt);
    bit found = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    cyc  = 0;
    bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        cyc   = i;
        found = 1;
        break;
      end
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  int cyc, bcnt, dcnt;
  int order [256];

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_diff", int'(bus.diff), 0);
    chk("rst_zero", int'(bus.zero), 0);
    rst = 1'b0;

    do_op(9, 4, cyc, bcnt);
    chk("lat_9_4", cyc, 5);
    chk("busy_len_9_4", bcnt, 4);
    chk("diff_9_4", int'(bus.diff), 5);
    chk("borrow_9_4", int'(bus.borrow), 0);
    chk("zero_9_4", int'(bus.zero), 0);
    chk("model_pin_9_4", exp_diff, 5);

    do_op(3, 5, cyc, bcnt);
    chk("diff_3_5", int'(bus.diff), 14);
    chk("borrow_3_5", int'(bus.borrow), 1);
    chk("zero_3_5", int'(bus.zero), 0);
    chk("model_pin_3_5", exp_borrow, 1);

    do_op(0, 0, cyc, bcnt);
    chk("diff_0_0", int'(bus.diff), 0);
    chk("borrow_0_0", int'(bus.borrow), 0);
    chk("zero_0_0", int'(bus.zero), 1);

    do_op(8, 1, cyc, bcnt);
    chk("diff_8_1", int'(bus.diff), 7);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("ovf_8_1", int'(bus.ovf), 1);
`else
    chk("ovf_8_1", int'(bus.ovf), 0);
`endif
    do_op(2, 5, cyc, bcnt);
    chk("diff_2_5", int'(bus.diff), 13);
    chk("ovf_2_5", int'(bus.ovf), 0);

    // Start held through RUN with changing operands, then back-to-back.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd7;
    bus.b = 4'd2;
    dcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.a = 4'd1;
        bus.b = 4'd1;
      end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin
        dcnt++;
        if (i == 5) chk("b2b_first_diff", int'(bus.diff), 5);
        if (i == 10) begin
          chk("b2b_second_diff", int'(bus.diff), 0);
          chk("b2b_second_zero", int'(bus.zero), 1);
        end
      end
    end
    chk("b2b_done_count", dcnt, 2);

    // Reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'd12;
    bus.b = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_diff", int'(bus.diff), 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    do_op(12, 3, cyc, bcnt);
    chk("diff_12_3", int'(bus.diff), 9);

    // Exhaustive sweep in shuffled order, start held high.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.a = W'(order[i] >> 4);
      bus.b = W'(order[i] & 15);
      repeat (W + 1) @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Random start/operand/reset traffic.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(3, 0) != 0);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      rst       = ($urandom_range(59, 0) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);

    chk("done_per_start", dut_done_cnt, m_done_cnt);
    chk("sweep_done_min", (m_done_cnt >= 256 + 9) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
